// File: rtl/pipe_skid_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake and two-entry skid buffer.
// Adds flush-to-bubble and a saturating count of stalled cycles; ready is registered-only to cut the stall path.
module pipe_skid_stage #(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   STALL,
    input  logic                   FLUSH,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [DATA_WIDTH-1:0]  DATA_IN,
    output logic                   OUT_VALID,
    output logic [DATA_WIDTH-1:0]  DATA_OUT,
    output logic [1:0]             OCCUPANCY,
    output logic [COUNT_WIDTH-1:0] STALL_COUNT
);

    // state | meaning: S_EMPTY no entry held; S_ONE main valid; S_FULL main and skid valid
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_main;
    logic [DATA_WIDTH-1:0]  r_skid;
    logic [COUNT_WIDTH-1:0] r_stall_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_drain;

    assign w_in_ready  = RESET & (r_state != S_FULL);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_accept    = IN_VALID & w_in_ready;
    assign w_drain     = w_out_valid & ~STALL;

    assign IN_READY    = w_in_ready;
    assign OUT_VALID   = w_out_valid;
    assign DATA_OUT    = w_out_valid ? r_main : BUBBLE_VALUE;
    assign STALL_COUNT = r_stall_count;

    always_comb begin
        OCCUPANCY = 2'd0;
        case (r_state)
            S_ONE:   OCCUPANCY = 2'd1;
            S_FULL:  OCCUPANCY = 2'd2;
            default: OCCUPANCY = 2'd0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_EMPTY;
            r_main  <= BUBBLE_VALUE;
            r_skid  <= BUBBLE_VALUE;
        end else if (FLUSH) begin
            // a beat accepted this cycle is consumed upstream and dropped here
            r_state <= S_EMPTY;
            r_main  <= BUBBLE_VALUE;
            r_skid  <= BUBBLE_VALUE;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state <= S_ONE;
                        r_main  <= DATA_IN;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        r_main <= DATA_IN;
                    end else if (w_accept) begin
                        r_state <= S_FULL;
                        r_skid  <= DATA_IN;
                    end else if (w_drain) begin
                        r_state <= S_EMPTY;
                        r_main  <= BUBBLE_VALUE;
                    end
                end
                S_FULL: begin
                    if (w_drain) begin
                        r_state <= S_ONE;
                        r_main  <= r_skid;
                        r_skid  <= BUBBLE_VALUE;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_main  <= BUBBLE_VALUE;
                    r_skid  <= BUBBLE_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_stall_count <= '0;
        end else if (w_out_valid && STALL && !FLUSH && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based reference model and scoreboard,
// directed scenarios (reset, streaming, skid, flush, saturation, empty stall) plus random traffic.
module tb_pipe_skid_stage;

    localparam int DW = 16;
    localparam int CW = 3;
    localparam logic [DW-1:0] BUB = '0;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          STALL;
    logic          FLUSH;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] DATA_IN;
    logic          OUT_VALID;
    logic [DW-1:0] DATA_OUT;
    logic [1:0]    OCCUPANCY;
    logic [CW-1:0] STALL_COUNT;

    int            n_checks = 0;
    int            n_fail   = 0;
    string         phase    = "init";
    logic [DW-1:0] q[$];
    int            m_cnt    = 0;

    pipe_skid_stage #(
        .DATA_WIDTH  (DW),
        .BUBBLE_VALUE(BUB),
        .COUNT_WIDTH (CW)
    ) u_dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .STALL      (STALL),
        .FLUSH      (FLUSH),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .DATA_IN    (DATA_IN),
        .OUT_VALID  (OUT_VALID),
        .DATA_OUT   (DATA_OUT),
        .OCCUPANCY  (OCCUPANCY),
        .STALL_COUNT(STALL_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s got=%0h expected=%0h t=%0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready",  32'(IN_READY),    32'(q.size() < 2));
        chk("out_valid", 32'(OUT_VALID),   32'(q.size() > 0));
        chk("data_out",  32'(DATA_OUT),    (q.size() > 0) ? 32'(q[0]) : 32'(BUB));
        chk("occupancy", 32'(OCCUPANCY),   32'(q.size()));
        chk("stall_cnt", 32'(STALL_COUNT), 32'(m_cnt));
    endtask

    // one clock cycle: drive at the falling edge, check, clock, update model
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic s, input logic f);
        logic acc;
        logic drn;
        IN_VALID = v;
        DATA_IN  = d;
        STALL    = s;
        FLUSH    = f;
        #1;
        check_outputs();
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && !s;
        if (drn && !f) chk("sb_drain", 32'(DATA_OUT), 32'(q[0]));
        @(posedge CLOCK);
        if ((q.size() > 0) && s && !f && (m_cnt < (1 << CW) - 1)) m_cnt++;
        if (f) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        @(negedge CLOCK);
    endtask

    task automatic idle(input int n, input logic s);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, s, 1'b0);
    endtask

    initial begin
        RESET    = 1'b0;
        STALL    = 1'b0;
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        DATA_IN  = '0;

        phase = "reset";
        #3;
        chk("rst_ready", 32'(IN_READY),    32'd0);
        chk("rst_valid", 32'(OUT_VALID),   32'd0);
        chk("rst_data",  32'(DATA_OUT),    32'(BUB));
        chk("rst_occ",   32'(OCCUPANCY),   32'd0);
        chk("rst_cnt",   32'(STALL_COUNT), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        chk("rel_ready", 32'(IN_READY), 32'd1);
        @(negedge CLOCK);

        phase = "stream";
        cyc(1'b1, 16'h00A1, 1'b0, 1'b0);
        cyc(1'b1, 16'h00A2, 1'b0, 1'b0);
        cyc(1'b1, 16'h00A3, 1'b0, 1'b0);
        idle(2, 1'b0);

        phase = "skid";
        cyc(1'b1, 16'h00B1, 1'b0, 1'b0);
        cyc(1'b1, 16'h00B2, 1'b1, 1'b0);
        cyc(1'b1, 16'h00B3, 1'b1, 1'b0);
        chk("skid_occ", 32'(OCCUPANCY), 32'd2);
        idle(3, 1'b0);

        phase = "flush_full";
        cyc(1'b1, 16'h00C1, 1'b0, 1'b0);
        cyc(1'b1, 16'h00C2, 1'b1, 1'b0);
        cyc(1'b1, 16'h00C3, 1'b1, 1'b1);
        idle(2, 1'b0);

        phase = "flush_one";
        cyc(1'b1, 16'h00D1, 1'b0, 1'b0);
        cyc(1'b1, 16'h00D2, 1'b0, 1'b1);
        idle(2, 1'b0);

        phase = "stall_empty";
        idle(4, 1'b1);

        phase = "reset_mid";
        cyc(1'b1, 16'h00E1, 1'b0, 1'b0);
        cyc(1'b1, 16'h00E2, 1'b1, 1'b0);
        idle(4, 1'b1);
        chk("pre_occ", 32'(OCCUPANCY), 32'd2);
        #1 RESET = 1'b0;
        #1;
        chk("mid_ready", 32'(IN_READY),    32'd0);
        chk("mid_valid", 32'(OUT_VALID),   32'd0);
        chk("mid_data",  32'(DATA_OUT),    32'(BUB));
        chk("mid_occ",   32'(OCCUPANCY),   32'd0);
        chk("mid_cnt",   32'(STALL_COUNT), 32'd0);
        q.delete();
        m_cnt = 0;
        #1 RESET = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(IN_READY), 32'd1);
        @(negedge CLOCK);

        phase = "saturate";
        cyc(1'b1, 16'h00F1, 1'b0, 1'b0);
        idle(10, 1'b1);
        chk("sat_cnt", 32'(STALL_COUNT), 32'd7);
        idle(2, 1'b0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        end
        idle(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
